// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared constants and fetch state type for the IF stage
package pc_fetch_unit_pkg;

    localparam int          PC_W_DEFAULT      = 9;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE   = 2'd0,
        FETCH_RUN    = 2'd1,
        FETCH_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory fetch bus between IF stage and imem
interface pc_fetch_unit_if
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - RV32I fetch front end: PC, imem fetch, IF/ID output, redirect/halt
// Optional redirect counter output enabled by PC_FETCH_REDIRECT_CNT_EN.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int          PC_W      = PC_W_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 PcSel,
    input  logic [31:0]          BrPC,
    input  logic                 Halt,
    input  logic                 Stall,
    pc_fetch_unit_if.master      imem,
    output logic                 if_valid,
    output logic [31:0]          if_instr,
    output logic [PC_W-1:0]      if_pc,
`ifdef PC_FETCH_REDIRECT_CNT_EN
    output logic [15:0]          redirect_cnt,
`endif
    output logic                 flush
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_d;
    logic [31:0]     instr_d;
    logic [PC_W-1:0] ipc_d;
    logic            flush_d;
    logic [PC_W-1:0] target;

    // Address bits above the implemented PC and the byte offset never reach pc_q.
    logic unused_brpc;
    assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

    assign target         = {BrPC[PC_W-1:2], 2'b00};
    assign imem.imem_req  = (state_q == FETCH_RUN);
    assign imem.imem_addr = pc_q;

`ifdef PC_FETCH_REDIRECT_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    assign redirect_cnt = cnt_q;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = if_valid;
        instr_d = if_instr;
        ipc_d   = if_pc;
        flush_d = 1'b0;
`ifdef PC_FETCH_REDIRECT_CNT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_RUN;
            end
            FETCH_RUN: begin
                // Redirect wins over stall and drops any data returned this cycle.
                if (PcSel) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    flush_d = 1'b1;
                    if (Halt) state_d = FETCH_HALTED;
`ifdef PC_FETCH_REDIRECT_CNT_EN
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`endif
                end else if (Stall) begin
                    pc_d = pc_q;
                end else if (imem.imem_valid) begin
                    instr_d = imem.imem_rdata;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_W'(4);
                end else begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end
            end
            FETCH_HALTED: begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= FETCH_IDLE;
            pc_q     <= '0;
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            if_pc    <= '0;
            flush    <= 1'b0;
`ifdef PC_FETCH_REDIRECT_CNT_EN
            cnt_q    <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            if_valid <= valid_d;
            if_instr <= instr_d;
            if_pc    <= ipc_d;
            flush    <= flush_d;
`ifdef PC_FETCH_REDIRECT_CNT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

    localparam int          PC_W = 9;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             pc_sel;
    logic [31:0]      br_pc;
    logic             halt;
    logic             stall;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [PC_W-1:0]  if_pc;
    logic             flush;
`ifdef PC_FETCH_REDIRECT_CNT_EN
    logic [15:0]      redirect_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_unit_if #(.PC_W(PC_W)) mem_if ();

    pc_fetch_unit #(.PC_W(PC_W), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .PcSel        (pc_sel),
        .BrPC         (br_pc),
        .Halt         (halt),
        .Stall        (stall),
        .imem         (mem_if),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
`ifdef PC_FETCH_REDIRECT_CNT_EN
        .redirect_cnt (redirect_cnt),
`endif
        .flush        (flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        return {16'hA5C3, 7'h00, a};
    endfunction

    assign mem_if.imem_rdata = mem_word(mem_if.imem_addr);

    // Reference model: 0 = not yet fetching, 1 = fetching, 2 = halted.
    int          m_mode;
    int          m_pc;
    int          m_ipc;
    int          m_valid;
    logic [31:0] m_instr;
    int          m_flush;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_ipc   = 0;
        m_valid = 0;
        m_instr = NOP;
        m_flush = 0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs(input string ph);
        check({ph, ".imem_req"},  {31'd0, mem_if.imem_req}, (m_mode == 1) ? 32'd1 : 32'd0);
        check({ph, ".imem_addr"}, {23'd0, mem_if.imem_addr}, 32'(m_pc));
        check({ph, ".if_valid"},  {31'd0, if_valid}, 32'(m_valid));
        check({ph, ".if_instr"},  if_instr, m_instr);
        check({ph, ".if_pc"},     {23'd0, if_pc}, 32'(m_ipc));
        check({ph, ".flush"},     {31'd0, flush}, 32'(m_flush));
`ifdef PC_FETCH_REDIRECT_CNT_EN
        check({ph, ".redirect_cnt"}, {16'd0, redirect_cnt}, 32'(m_cnt));
`endif
    endtask

    // Apply the current inputs for one clock and compare against the model.
    task automatic step(input string ph);
        m_flush = 0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (pc_sel) begin
                m_pc    = int'(br_pc) & 32'h1FC;
                m_valid = 0;
                m_instr = NOP;
                m_flush = 1;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (halt) m_mode = 2;
            end else if (!stall) begin
                if (mem_if.imem_valid) begin
                    m_instr = mem_word(PC_W'(m_pc));
                    m_ipc   = m_pc;
                    m_valid = 1;
                    m_pc    = (m_pc + 4) % 512;
                end else begin
                    m_valid = 0;
                    m_instr = NOP;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs(ph);
    endtask

    task automatic idle_inputs();
        pc_sel = 1'b0;
        br_pc  = 32'd0;
        halt   = 1'b0;
        stall  = 1'b0;
        mem_if.imem_valid = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        reset_n = 1'b1;

        // Streaming with same-cycle memory, long enough to wrap 508 -> 0.
        for (int i = 0; i < 140; i++) step("stream");

        // Memory answers on the third cycle of each fetch.
        for (int i = 0; i < 30; i++) begin
            mem_if.imem_valid = ((i % 3) == 2);
            step("wait");
        end

        // Stall for three cycles with the PC sitting at 0x10.
        mem_if.imem_valid = 1'b1;
        pc_sel = 1'b1; br_pc = 32'h10;
        step("to10");
        pc_sel = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) step("stall");
        check("stall.addr", {23'd0, mem_if.imem_addr}, 32'h10);
        stall = 1'b0;
        step("unstall");
        check("unstall.if_pc", {23'd0, if_pc}, 32'h10);

        // Redirect beats concurrent stall and returned data.
        stall = 1'b1; pc_sel = 1'b1; br_pc = 32'hFFFF_FE43;
        step("redir");
        check("redir.addr", {23'd0, mem_if.imem_addr}, 32'h40);
        pc_sel = 1'b0; stall = 1'b0;
        step("post_redir");
        check("post_redir.flush", {31'd0, flush}, 32'd0);

        // Back-to-back redirects.
        pc_sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            br_pc = $urandom;
            step("b2b");
        end
        pc_sel = 1'b0;

        // Randomized mix of waits, stalls and redirects.
        for (int i = 0; i < 2000; i++) begin
            mem_if.imem_valid = ($urandom_range(0, 99) < 70);
            stall  = ($urandom_range(0, 99) < 20);
            pc_sel = ($urandom_range(0, 99) < 8);
            br_pc  = $urandom;
            step("rand");
        end

        // Halt, then everything except reset is ignored.
        idle_inputs();
        pc_sel = 1'b1; halt = 1'b1; br_pc = 32'h24;
        step("halt");
        check("halt.addr", {23'd0, mem_if.imem_addr}, 32'h24);
        for (int i = 0; i < 20; i++) begin
            mem_if.imem_valid = $urandom_range(0, 1);
            stall  = $urandom_range(0, 1);
            pc_sel = $urandom_range(0, 1);
            halt   = $urandom_range(0, 1);
            br_pc  = $urandom;
            step("halted");
        end

        // Restart, run a bit, then asynchronous reset mid-cycle.
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst2");
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step("restart");
        pc_sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            br_pc = $urandom;
            step("cnt");
        end
        pc_sel = 1'b0;
        step("cnt_done");
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_outputs("rst_hold");
        for (int i = 0; i < 5; i++) step("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
